// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_queue
// Brief    : Instruction-fetch stage with a DEPTH-entry {PC, instruction}
//            prefetch queue, valid/ready decode handshake and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     PCSrc,
    input  logic [31:0]              PC_Branch,
    input  logic                     id_ready,
    input  logic [31:0]              imem_rdata,
    output logic [IMEM_AW-1:0]       imem_addr,
    output logic                     if_valid,
    output logic [31:0]              PC_IF,
    output logic [31:0]              INSTRUCTION_IF,
    output logic [$clog2(DEPTH):0]   if_count
);

    localparam int               c_PW      = $clog2(DEPTH);
    localparam int               c_CW      = c_PW + 1;
    localparam logic [c_CW-1:0]  c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_PW-1:0]  c_PTR_ONE = c_PW'(1);
    localparam logic [c_CW-1:0]  c_CNT_ONE = c_CW'(1);

    logic [31:0]     r_fetch_pc;
    logic [c_PW-1:0] r_head;
    logic [c_PW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic [63:0]     r_buf [DEPTH];

    logic            w_pop;
    logic            w_push;
    logic            w_nonempty;
    logic [63:0]     w_head_entry;
    logic            w_unused_branch_lsbs;

    // Branch targets are word-aligned by truncation, so the low bits are never read.
    assign w_unused_branch_lsbs = ^PC_Branch[1:0];

    always_comb begin
        w_nonempty = (r_count != '0);
        w_pop      = w_nonempty & id_ready & ~PCSrc;
        // A full queue may still accept a fetch when the head leaves this cycle.
        w_push     = ~PCSrc & ((r_count < c_DEPTH) | w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (PCSrc) begin
            r_fetch_pc <= {PC_Branch[31:2], 2'b00};
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_tail     <= r_tail + c_PTR_ONE;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_tail] <= {r_fetch_pc, imem_rdata};
        end
    end

    assign w_head_entry   = r_buf[r_head];
    assign imem_addr      = r_fetch_pc[IMEM_AW+1:2];
    assign if_valid       = w_nonempty;
    assign if_count       = r_count;
    assign PC_IF          = w_nonempty ? w_head_entry[63:32] : 32'h0000_0000;
    assign INSTRUCTION_IF = w_nonempty ? w_head_entry[31:0]  : NOP;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch_queue
// Brief    : Vector table plus queue scoreboard for if_prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc = 1'b0;
    logic [31:0] PC_Branch = 32'h0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [9:0]  imem_addr;
    logic        if_valid;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic [2:0]  if_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_pc = 32'h0;

    typedef struct {
        logic        rst;
        logic        pcsrc;
        logic [31:0] br;
        logic        rdy;
        int          cnt;
        logic        vld;
        logic [31:0] pc;
        logic [9:0]  addr;
    } vec_t;

    vec_t vecs[27];

    if_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (10),
        .NOP      (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .PC_Branch      (PC_Branch),
        .id_ready       (id_ready),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .if_valid       (if_valid),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF),
        .if_count       (if_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at index a holds a*4 + 0x100.
    assign imem_rdata = {20'h0, imem_addr, 2'b00} + 32'h100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic rst, input logic pcsrc, input logic [31:0] br,
                        input logic rdy, input int cnt, input logic vld, input logic [31:0] pc,
                        input logic [9:0] addr);
        vecs[i] = '{rst, pcsrc, br, rdy, cnt, vld, pc, addr};
    endtask

    task automatic drive(input logic rst, input logic pcsrc, input logic [31:0] br, input logic rdy);
        reset     = rst;
        PCSrc     = pcsrc;
        PC_Branch = br;
        id_ready  = rdy;
        #1;
    endtask

    // Releases any row reset, runs the reference queue for this cycle, then clocks.
    task automatic advance(input logic rst);
        logic [63:0] e;
        bit          pop;
        bit          push;
        if (rst) begin
            reset = 1'b0;
            m_q.delete();
            m_pc = 32'h0;
        end
        chk("sb_count", 32'(if_count), 32'(m_q.size()));
        if (PCSrc) begin
            m_q.delete();
            m_pc = {PC_Branch[31:2], 2'b00};
        end else begin
            pop  = (m_q.size() != 0) && id_ready;
            push = (m_q.size() < DEPTH) || pop;
            if (pop) begin
                e = m_q.pop_front();
                chk("sb_pc", PC_IF, e[63:32]);
                chk("sb_instr", INSTRUCTION_IF, e[31:0]);
            end
            if (push) begin
                m_q.push_back({m_pc, (m_pc & 32'h0000_0FFC) + 32'h100});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Straight-line fetch with decode always ready.
        setv( 0, 1, 0, 32'h0,   1, 0, 0, 32'h0,   10'h0);
        setv( 1, 0, 0, 32'h0,   1, 1, 1, 32'h0,   10'h1);
        setv( 2, 0, 0, 32'h0,   1, 1, 1, 32'h4,   10'h2);
        setv( 3, 0, 0, 32'h0,   1, 1, 1, 32'h8,   10'h3);
        setv( 4, 0, 0, 32'h0,   1, 1, 1, 32'hC,   10'h4);
        // Stall until full, then drain with simultaneous refill.
        setv( 5, 1, 0, 32'h0,   0, 0, 0, 32'h0,   10'h0);
        setv( 6, 0, 0, 32'h0,   0, 1, 1, 32'h0,   10'h1);
        setv( 7, 0, 0, 32'h0,   0, 2, 1, 32'h0,   10'h2);
        setv( 8, 0, 0, 32'h0,   0, 3, 1, 32'h0,   10'h3);
        setv( 9, 0, 0, 32'h0,   0, 4, 1, 32'h0,   10'h4);
        setv(10, 0, 0, 32'h0,   0, 4, 1, 32'h0,   10'h4);
        setv(11, 0, 0, 32'h0,   1, 4, 1, 32'h0,   10'h4);
        setv(12, 0, 0, 32'h0,   1, 4, 1, 32'h4,   10'h5);
        setv(13, 0, 0, 32'h0,   1, 4, 1, 32'h8,   10'h6);
        setv(14, 0, 0, 32'h0,   1, 4, 1, 32'hC,   10'h7);
        setv(15, 0, 0, 32'h0,   1, 4, 1, 32'h10,  10'h8);
        // Redirect to a misaligned target with three entries queued.
        setv(16, 1, 0, 32'h0,   0, 0, 0, 32'h0,   10'h0);
        setv(17, 0, 0, 32'h0,   0, 1, 1, 32'h0,   10'h1);
        setv(18, 0, 0, 32'h0,   0, 2, 1, 32'h0,   10'h2);
        setv(19, 0, 1, 32'h203, 0, 3, 1, 32'h0,   10'h3);
        setv(20, 0, 0, 32'h0,   0, 0, 0, 32'h0,   10'h80);
        setv(21, 0, 0, 32'h0,   1, 1, 1, 32'h200, 10'h81);
        setv(22, 0, 0, 32'h0,   1, 1, 1, 32'h204, 10'h82);
        // Redirect while decode is ready: head 0x208 must not be consumed.
        setv(23, 0, 1, 32'h40,  1, 1, 1, 32'h208, 10'h83);
        setv(24, 0, 0, 32'h0,   1, 0, 0, 32'h0,   10'h10);
        setv(25, 0, 0, 32'h0,   1, 1, 1, 32'h40,  10'h11);
        setv(26, 0, 0, 32'h0,   1, 1, 1, 32'h44,  10'h12);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst, vecs[i].pcsrc, vecs[i].br, vecs[i].rdy);
            chk($sformatf("v%0d_count", i), 32'(if_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d_pc", i), PC_IF, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), INSTRUCTION_IF,
                vecs[i].vld ? vecs[i].pc + 32'h100 : NOP);
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            advance(vecs[i].rst);
        end

        // Asynchronous reset mid-cycle with two entries queued.
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        advance(1'b0);
        chk("pre_rst_count", 32'(if_count), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_count", 32'(if_count), 32'd0);
        chk("arst_pc", PC_IF, 32'h0);
        chk("arst_instr", INSTRUCTION_IF, NOP);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_count", 32'(if_count), 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_valid", 32'(if_valid), 32'd1);
        chk("restart_count", 32'(if_count), 32'd1);
        chk("restart_pc", PC_IF, 32'h0);
        chk("restart_instr", INSTRUCTION_IF, 32'h100);
        chk("restart_addr", 32'(imem_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
